// File: rtl/cache_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cache_mem_arbiter
// Brief    : Round-robin arbiter between icache and dcache line transfers,
//            feeding a single-request line-transfer bridge.
// Revision : 1.0 - initial release
// ============================================================================
module cache_mem_arbiter #(
    parameter int ADDR_LEN   = 32,
    parameter int LINE_WORDS = 8
) (
    input  logic                     aclk,
    input  logic                     areset,
    input  logic                     ic_req,
    input  logic [ADDR_LEN-1:0]      ic_addr,
    output logic                     ic_gnt,
    output logic [32*LINE_WORDS-1:0] ic_rd_line,
    input  logic                     dc_rd_req,
    input  logic                     dc_wr_req,
    input  logic [ADDR_LEN-1:0]      dc_addr,
    input  logic [32*LINE_WORDS-1:0] dc_wr_line,
    output logic                     dc_gnt,
    output logic [32*LINE_WORDS-1:0] dc_rd_line,
    output logic                     mem_rd_req,
    output logic                     mem_wr_req,
    output logic [ADDR_LEN-1:0]      mem_addr,
    output logic [32*LINE_WORDS-1:0] mem_wr_line,
    input  logic                     mem_gnt,
    input  logic [32*LINE_WORDS-1:0] mem_rd_line
);

    localparam int   c_LINE_BITS = 32 * LINE_WORDS;
    localparam logic c_OWN_IC    = 1'b0;
    localparam logic c_OWN_DC    = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic                   r_owner;
    logic                   r_rr_last;
    logic                   r_wr;
    logic [ADDR_LEN-1:0]    r_addr;
    logic [c_LINE_BITS-1:0] r_wr_line;
    logic [c_LINE_BITS-1:0] r_ic_rd_line;
    logic [c_LINE_BITS-1:0] r_dc_rd_line;

    logic w_dc_any;
    logic w_any_req;
    logic w_pick_dc;

    assign w_dc_any  = dc_rd_req | dc_wr_req;
    assign w_any_req = ic_req | w_dc_any;
    // On contention the side that was not served last wins.
    assign w_pick_dc = w_dc_any & (~ic_req | (r_rr_last == c_OWN_IC));

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_any_req) w_state_next = S_BUSY;
            S_BUSY:  if (mem_gnt)   w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_owner      <= c_OWN_IC;
            r_rr_last    <= c_OWN_IC;
            r_wr         <= 1'b0;
            r_addr       <= '0;
            r_wr_line    <= '0;
            r_ic_rd_line <= '0;
            r_dc_rd_line <= '0;
        end else begin
            if (r_state == S_IDLE && w_any_req) begin
                r_owner <= w_pick_dc;
                r_addr  <= w_pick_dc ? dc_addr : ic_addr;
                r_wr    <= w_pick_dc & dc_wr_req;
                if (w_pick_dc) begin
                    r_wr_line <= dc_wr_line;
                end
            end
            // Refill data lands only in the owner's buffer; write-backs leave both alone.
            if (r_state == S_BUSY && mem_gnt) begin
                r_rr_last <= r_owner;
                if (!r_wr) begin
                    if (r_owner == c_OWN_DC) begin
                        r_dc_rd_line <= mem_rd_line;
                    end else begin
                        r_ic_rd_line <= mem_rd_line;
                    end
                end
            end
        end
    end

    assign mem_rd_req  = (r_state == S_BUSY) & ~r_wr;
    assign mem_wr_req  = (r_state == S_BUSY) &  r_wr;
    assign mem_addr    = r_addr;
    assign mem_wr_line = r_wr_line;
    assign ic_gnt      = (r_state == S_DONE) & (r_owner == c_OWN_IC);
    assign dc_gnt      = (r_state == S_DONE) & (r_owner == c_OWN_DC);
    assign ic_rd_line  = r_ic_rd_line;
    assign dc_rd_line  = r_dc_rd_line;

endmodule
`default_nettype wire

// File: tb/tb_cache_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_cache_mem_arbiter
// Brief    : Directed vector table plus hand-written corner sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cache_mem_arbiter;

    localparam int AL = 32;
    localparam int LB = 256;

    logic          aclk = 1'b0;
    logic          areset;
    logic          ic_req;
    logic [AL-1:0] ic_addr;
    logic          ic_gnt;
    logic [LB-1:0] ic_rd_line;
    logic          dc_rd_req;
    logic          dc_wr_req;
    logic [AL-1:0] dc_addr;
    logic [LB-1:0] dc_wr_line;
    logic          dc_gnt;
    logic [LB-1:0] dc_rd_line;
    logic          mem_rd_req;
    logic          mem_wr_req;
    logic [AL-1:0] mem_addr;
    logic [LB-1:0] mem_wr_line;
    logic          mem_gnt;
    logic [LB-1:0] mem_rd_line;

    int total = 0;
    int bad   = 0;

    cache_mem_arbiter #(.ADDR_LEN(AL), .LINE_WORDS(8)) dut (
        .aclk(aclk), .areset(areset),
        .ic_req(ic_req), .ic_addr(ic_addr), .ic_gnt(ic_gnt), .ic_rd_line(ic_rd_line),
        .dc_rd_req(dc_rd_req), .dc_wr_req(dc_wr_req), .dc_addr(dc_addr),
        .dc_wr_line(dc_wr_line), .dc_gnt(dc_gnt), .dc_rd_line(dc_rd_line),
        .mem_rd_req(mem_rd_req), .mem_wr_req(mem_wr_req), .mem_addr(mem_addr),
        .mem_wr_line(mem_wr_line), .mem_gnt(mem_gnt), .mem_rd_line(mem_rd_line)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic          ic_req;
        logic [AL-1:0] ic_addr;
        logic          dc_rd;
        logic          dc_wr;
        logic [AL-1:0] dc_addr;
        logic [LB-1:0] dc_wr_line;
        logic          mem_gnt;
        logic [LB-1:0] mem_rd_line;
        logic          e_rd;
        logic          e_wr;
        logic [AL-1:0] e_addr;
        logic [LB-1:0] e_wr_line;
        logic          e_ic_gnt;
        logic          e_dc_gnt;
        logic [LB-1:0] e_ic_line;
        logic [LB-1:0] e_dc_line;
    } vec_t;

    vec_t vec [11];

    function automatic logic [LB-1:0] mkline(input logic [31:0] base);
        logic [LB-1:0] l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = base + i;
        return l;
    endfunction

    task automatic chk(input string name, input logic [LB-1:0] act, input logic [LB-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic idle_inputs();
        ic_req = 0; ic_addr = '0; dc_rd_req = 0; dc_wr_req = 0; dc_addr = '0;
        dc_wr_line = '0; mem_gnt = 0; mem_rd_line = '0;
    endtask

    task automatic do_reset();
        areset = 1;
        step();
        areset = 0;
    endtask

    logic [LB-1:0] z, la0, l10, l50, lee, l30, lb0, lc0, ld0;
    logic [AL-1:0] ia, da, db;

    initial begin
        z = '0;
        la0 = mkline(32'hA0); l10 = mkline(32'h10); l50 = mkline(32'h50);
        lee = mkline(32'hEE); l30 = mkline(32'h30); lb0 = mkline(32'hB0);
        lc0 = mkline(32'hC0); ld0 = mkline(32'hD0);
        ia = 32'h1FC0_0100; da = 32'h0000_2000; db = 32'h0000_3000;

        vec[0]  = '{1, ia, 0, 0, 0,  z,   0, z,   1, 0, ia, z,   0, 0, z,   z};
        vec[1]  = '{1, ia, 0, 0, 0,  z,   1, la0, 0, 0, ia, z,   1, 0, la0, z};
        vec[2]  = '{0, 0,  0, 0, 0,  z,   0, z,   0, 0, ia, z,   0, 0, la0, z};
        vec[3]  = '{0, 0,  0, 1, da, l10, 0, z,   0, 1, da, l10, 0, 0, la0, z};
        vec[4]  = '{0, 0,  0, 1, da, l50, 0, z,   0, 1, da, l10, 0, 0, la0, z};
        vec[5]  = '{0, 0,  0, 1, da, l50, 1, lee, 0, 0, da, l10, 0, 1, la0, z};
        vec[6]  = '{0, 0,  0, 0, 0,  z,   0, z,   0, 0, da, l10, 0, 0, la0, z};
        vec[7]  = '{0, 0,  0, 0, 0,  z,   1, lee, 0, 0, da, l10, 0, 0, la0, z};
        vec[8]  = '{0, 0,  1, 1, db, l30, 0, z,   0, 1, db, l30, 0, 0, la0, z};
        vec[9]  = '{0, 0,  1, 1, db, l30, 1, lee, 0, 0, db, l30, 0, 1, la0, z};
        vec[10] = '{0, 0,  0, 0, 0,  z,   0, z,   0, 0, db, l30, 0, 0, la0, z};

        // Reset state
        idle_inputs();
        areset = 1;
        step();
        step();
        chk("rst_mem_rd", {255'b0, mem_rd_req}, 0);
        chk("rst_mem_wr", {255'b0, mem_wr_req}, 0);
        chk("rst_mem_addr", {224'b0, mem_addr}, 0);
        chk("rst_mem_wr_line", mem_wr_line, 0);
        chk("rst_gnts", {254'b0, ic_gnt, dc_gnt}, 0);
        chk("rst_lines", ic_rd_line | dc_rd_line, 0);
        areset = 0;
        step();

        // Directed vector table
        for (int i = 0; i < 11; i++) begin
            ic_req = vec[i].ic_req; ic_addr = vec[i].ic_addr;
            dc_rd_req = vec[i].dc_rd; dc_wr_req = vec[i].dc_wr;
            dc_addr = vec[i].dc_addr; dc_wr_line = vec[i].dc_wr_line;
            mem_gnt = vec[i].mem_gnt; mem_rd_line = vec[i].mem_rd_line;
            step();
            chk($sformatf("v%0d_mem_rd", i), {255'b0, mem_rd_req}, {255'b0, vec[i].e_rd});
            chk($sformatf("v%0d_mem_wr", i), {255'b0, mem_wr_req}, {255'b0, vec[i].e_wr});
            chk($sformatf("v%0d_mem_addr", i), {224'b0, mem_addr}, {224'b0, vec[i].e_addr});
            chk($sformatf("v%0d_mem_wr_line", i), mem_wr_line, vec[i].e_wr_line);
            chk($sformatf("v%0d_ic_gnt", i), {255'b0, ic_gnt}, {255'b0, vec[i].e_ic_gnt});
            chk($sformatf("v%0d_dc_gnt", i), {255'b0, dc_gnt}, {255'b0, vec[i].e_dc_gnt});
            chk($sformatf("v%0d_ic_line", i), ic_rd_line, vec[i].e_ic_line);
            chk($sformatf("v%0d_dc_line", i), dc_rd_line, vec[i].e_dc_line);
        end

        // Contention with both requests held: dc, ic, dc
        idle_inputs();
        do_reset();
        ic_req = 1; ic_addr = 32'h0000_1100; dc_rd_req = 1; dc_addr = 32'h0000_2200;
        step();
        chk("arb1_addr", {224'b0, mem_addr}, {224'b0, 32'h0000_2200});
        chk("arb1_rd", {255'b0, mem_rd_req}, 1);
        mem_gnt = 1; mem_rd_line = lb0;
        step();
        mem_gnt = 0;
        chk("arb1_gnt", {254'b0, ic_gnt, dc_gnt}, {254'b0, 2'b01});
        chk("arb1_dc_line", dc_rd_line, lb0);
        step();
        step();
        chk("arb2_addr", {224'b0, mem_addr}, {224'b0, 32'h0000_1100});
        mem_gnt = 1; mem_rd_line = lc0;
        step();
        mem_gnt = 0;
        chk("arb2_gnt", {254'b0, ic_gnt, dc_gnt}, {254'b0, 2'b10});
        chk("arb2_ic_line", ic_rd_line, lc0);
        chk("arb2_dc_line_hold", dc_rd_line, lb0);
        step();
        step();
        chk("arb3_addr", {224'b0, mem_addr}, {224'b0, 32'h0000_2200});
        mem_gnt = 1; mem_rd_line = ld0;
        step();
        mem_gnt = 0;
        chk("arb3_gnt", {254'b0, ic_gnt, dc_gnt}, {254'b0, 2'b01});
        ic_req = 0; dc_rd_req = 0;
        step();

        // Bridge stalls for 20 cycles
        ic_req = 1; ic_addr = 32'h0000_4440;
        step();
        for (int i = 0; i < 20; i++) begin
            chk($sformatf("stall%0d", i), {223'b0, mem_rd_req, mem_addr},
                {223'b0, 1'b1, 32'h0000_4440});
            step();
        end
        mem_gnt = 1; mem_rd_line = la0;
        step();
        mem_gnt = 0; ic_req = 0;
        chk("stall_gnt", {254'b0, ic_gnt, mem_rd_req}, {254'b0, 2'b10});
        step();
        chk("stall_gap1", {254'b0, ic_gnt, mem_rd_req}, 0);
        step();
        chk("stall_gap2", {255'b0, mem_rd_req}, 0);

        // Async reset mid-transaction
        ic_req = 1; ic_addr = 32'h0000_5500;
        step();
        chk("ar_busy", {255'b0, mem_rd_req}, 1);
        #2 areset = 1;
        #1;
        chk("ar_req_drop", {254'b0, mem_rd_req, mem_wr_req}, 0);
        chk("ar_addr_zero", {224'b0, mem_addr}, 0);
        chk("ar_line_zero", ic_rd_line | dc_rd_line, 0);
        @(posedge aclk);
        #1 areset = 0;
        step();
        chk("ar_restart", {222'b0, ic_gnt, dc_gnt, mem_rd_req, mem_addr},
            {222'b0, 3'b001, 32'h0000_5500});
        mem_gnt = 1; mem_rd_line = lee;
        step();
        mem_gnt = 0; ic_req = 0;
        chk("ar_gnt", {254'b0, ic_gnt, dc_gnt}, {254'b0, 2'b10});
        chk("ar_ic_line", ic_rd_line, lee);
        step();
        chk("ar_no_extra_gnt", {254'b0, ic_gnt, dc_gnt}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
